// File: rtl/instr_fe.sv
// RV32I instruction fetch stage: keeps the PC, fetches words over a req/ack port,
// and feeds decode through a one-entry stall buffer with redirect/flush handling.
module instr_fe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        decode_en_o,
  input  logic        fetch_stall_i,
  input  logic        fetch_flush_i,
  input  logic        fetch_change_pc_i,
  input  logic [31:0] fetch_new_pc_i,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is imem_req_o=1 with imem_addr_o held stable; it completes
  // in the cycle imem_ack_i=1 (data on imem_rdata_i that same cycle). Ack without
  // req is ignored. Reset withdraws any outstanding request.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic        buf_valid_q, buf_valid_n;
  logic [31:0] buf_instr_q, buf_instr_n;
  logic [31:0] buf_pc_q, buf_pc_n;
  logic [31:0] instr_n, fpc_n;
  logic        en_n;
  logic        ack_take;
  logic        unused_new_pc_lsbs;

  assign unused_new_pc_lsbs = ^fetch_new_pc_i[1:0];

  assign imem_addr_o = pc_q;
  assign imem_req_o  = (state_q == FETCH && !buf_valid_q) || state_q == DISCARD;
  assign ack_take    = imem_ack_i && imem_req_o;
  assign dbg_state   = state_q;

  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    buf_valid_n = buf_valid_q;
    buf_instr_n = buf_instr_q;
    buf_pc_n    = buf_pc_q;
    instr_n     = fetch_instr_o;
    fpc_n       = fetch_pc_o;
    en_n        = decode_en_o;

    if (fetch_change_pc_i) begin
      pc_n        = {fetch_new_pc_i[31:2], 2'b00};
      en_n        = 1'b0;
      instr_n     = NOP_INSTR;
      buf_valid_n = 1'b0;
      // A request already on the bus must complete before the new PC can be fetched.
      if (state_q == DISCARD || (state_q == FETCH && imem_req_o && !imem_ack_i))
        state_n = DISCARD;
      else
        state_n = FETCH;
    end else if (fetch_flush_i) begin
      en_n        = 1'b0;
      instr_n     = NOP_INSTR;
      buf_valid_n = 1'b0;
      if (state_q != DISCARD || imem_ack_i)
        state_n = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_n = FETCH;
        DISCARD: begin
          if (imem_ack_i) state_n = FETCH;
          if (!fetch_stall_i) begin
            en_n    = 1'b0;
            instr_n = NOP_INSTR;
          end
        end
        FETCH: begin
          if (fetch_stall_i) begin
            if (ack_take) begin
              buf_instr_n = imem_rdata_i;
              buf_pc_n    = pc_q;
              buf_valid_n = 1'b1;
              pc_n        = pc_q + 32'd4;
            end
          end else if (buf_valid_q) begin
            instr_n     = buf_instr_q;
            fpc_n       = buf_pc_q;
            en_n        = 1'b1;
            buf_valid_n = 1'b0;
          end else if (ack_take) begin
            instr_n = imem_rdata_i;
            fpc_n   = pc_q;
            en_n    = 1'b1;
            pc_n    = pc_q + 32'd4;
          end else begin
            en_n    = 1'b0;
            instr_n = NOP_INSTR;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_valid_q   <= 1'b0;
      buf_instr_q   <= NOP_INSTR;
      buf_pc_q      <= RESET_PC;
      fetch_instr_o <= NOP_INSTR;
      fetch_pc_o    <= RESET_PC;
      decode_en_o   <= 1'b0;
    end else begin
      state_q       <= state_n;
      pc_q          <= pc_n;
      buf_valid_q   <= buf_valid_n;
      buf_instr_q   <= buf_instr_n;
      buf_pc_q      <= buf_pc_n;
      fetch_instr_o <= instr_n;
      fetch_pc_o    <= fpc_n;
      decode_en_o   <= en_n;
    end
  end

endmodule

// File: tb/tb_instr_fe.sv
// Bench for instr_fe: directed scenarios then random traffic, each cycle compared
// against a transaction-level fetch model with a latching instruction memory.
module tb_instr_fe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        decode_en_o;
  logic        fetch_stall_i = 1'b0;
  logic        fetch_flush_i = 1'b0;
  logic        fetch_change_pc_i = 1'b0;
  logic [31:0] fetch_new_pc_i = 32'h0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  instr_fe dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ack_i        (imem_ack_i),
    .imem_rdata_i      (imem_rdata_i),
    .fetch_instr_o     (fetch_instr_o),
    .fetch_pc_o        (fetch_pc_o),
    .decode_en_o       (decode_en_o),
    .fetch_stall_i     (fetch_stall_i),
    .fetch_flush_i     (fetch_flush_i),
    .fetch_change_pc_i (fetch_change_pc_i),
    .fetch_new_pc_i    (fetch_new_pc_i),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction memory ----------------
  // Latches the address when a request starts waiting, so late data belongs to it.
  logic        ack_drv = 1'b0;
  logic        mem_busy;
  logic [31:0] mem_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h1;
  endfunction

  assign imem_ack_i   = ack_drv;
  assign imem_rdata_i = !imem_ack_i ? 32'hDEAD_BEEF :
                        (mem_busy ? mem_word(mem_lat) : mem_word(imem_addr_o));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy <= 1'b0;
      mem_lat  <= 32'h0;
    end else if (imem_req_o && imem_ack_i) begin
      mem_busy <= 1'b0;
    end else if (imem_req_o && !mem_busy) begin
      mem_busy <= 1'b1;
      mem_lat  <= imem_addr_o;
    end
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_started;
  bit          m_discard;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic [63:0] hold_q[$];
  logic [64:0] exp_q[$];

  task automatic model_reset();
    m_started = 0;
    m_discard = 0;
    m_pc      = 32'h0;
    m_valid   = 0;
    m_instr   = NOP;
    m_opc     = 32'h0;
    hold_q.delete();
    exp_q.delete();
  endtask

  function automatic bit m_req();
    return m_discard || (m_started && hold_q.size() == 0);
  endfunction

  task automatic model_invalidate();
    m_valid = 0;
    m_instr = NOP;
  endtask

  task automatic model_step(input bit stall, input bit flush, input bit chg,
                            input logic [31:0] npc, input bit ack);
    bit req;
    bit took;
    logic [63:0] e;
    req  = m_req();
    took = ack && req;
    if (!m_started) begin
      m_started = 1;
      if (chg) m_pc = {npc[31:2], 2'b00};
      if (chg || flush) model_invalidate();
    end else if (chg) begin
      if (!m_discard && req && !ack) m_discard = 1;
      m_pc = {npc[31:2], 2'b00};
      model_invalidate();
      hold_q.delete();
    end else if (m_discard) begin
      if (ack) m_discard = 0;
    end else if (flush) begin
      model_invalidate();
      hold_q.delete();
    end else if (stall) begin
      if (took) begin
        hold_q.push_back({mem_word(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end else if (hold_q.size() != 0) begin
      e       = hold_q.pop_front();
      m_valid = 1;
      m_instr = e[63:32];
      m_opc   = e[31:0];
    end else if (took) begin
      m_valid = 1;
      m_instr = mem_word(m_pc);
      m_opc   = m_pc;
      m_pc    = m_pc + 32'd4;
    end else begin
      model_invalidate();
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input bit stall, input bit flush, input bit chg,
                       input logic [31:0] npc, input bit ack);
    logic [64:0] e;
    fetch_stall_i     = stall;
    fetch_flush_i     = flush;
    fetch_change_pc_i = chg;
    fetch_new_pc_i    = npc;
    ack_drv           = ack;
    @(negedge clk);
    check_eq("req", imem_req_o, m_req());
    check_eq("addr", imem_addr_o, m_pc);
    model_step(stall, flush, chg, npc, ack);
    exp_q.push_back({m_valid, m_opc, m_instr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("en", decode_en_o, e[64]);
    check_eq("pc", fetch_pc_o, e[63:32]);
    check_eq("instr", fetch_instr_o, e[31:0]);
    if (decode_en_o) check_eq("data", fetch_instr_o, mem_word(fetch_pc_o));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"}, imem_req_o, 0);
    check_eq({tag, "_addr"}, imem_addr_o, 32'h0);
    check_eq({tag, "_en"}, decode_en_o, 0);
    check_eq({tag, "_instr"}, fetch_instr_o, NOP);
    check_eq({tag, "_pc"}, fetch_pc_o, 32'h0);
    check_eq({tag, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // zero-wait stream from reset
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("idle_bubble", decode_en_o, 0);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("first_valid", decode_en_o, 1);
    check_eq("first_pc", fetch_pc_o, 32'h0);
    repeat (3) cycle(0, 0, 0, 32'h0, 1);
    check_eq("pc_c", fetch_pc_o, 32'hC);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("pc_10", fetch_pc_o, 32'h10);

    // stall for 4 cycles while 0x14 is acked into the buffer
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 32'h0, 1);
      check_eq("stall_hold", fetch_pc_o, 32'h10);
    end
    check_eq("stall_req_drop", imem_req_o, 0);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("release_pc", fetch_pc_o, 32'h14);
    check_eq("release_next_addr", imem_addr_o, 32'h18);
    check_eq("release_next_req", imem_req_o, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // memory acking every third cycle
    nv = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 32'h0, (i % 3) == 2);
      nv += int'(decode_en_o);
    end
    check_eq("slow_valid_count", nv, 3);
    check_eq("slow_last_pc", fetch_pc_o, 32'h24);

    // redirect while the 0x40 request is pending
    repeat (6) cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 0, 1, 32'h200, 0);
    check_eq("discard_state", dbg_state, 2'd2);
    check_eq("discard_addr", imem_addr_o, 32'h200);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("discard_dropped", decode_en_o, 0);
    check_eq("discard_exit", dbg_state, 2'd1);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("redir_pc", fetch_pc_o, 32'h200);
    check_eq("redir_instr", fetch_instr_o, 32'h201);

    // redirect under stall with a full buffer and a same-cycle ack
    cycle(1, 0, 0, 32'h0, 1);
    cycle(1, 0, 1, 32'h103, 1);
    check_eq("redir_stall_addr", imem_addr_o, 32'h100);
    check_eq("redir_stall_en", decode_en_o, 0);
    check_eq("redir_stall_state", dbg_state, 2'd1);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("no_stale_pc", fetch_pc_o, 32'h100);

    // address wrap
    cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
    check_eq("wrap_a0", imem_addr_o, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("wrap_a1", imem_addr_o, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("wrap_a2", imem_addr_o, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    check_eq("wrap_pc", fetch_pc_o, 32'h0);
    cycle(0, 0, 0, 32'h0, 0);

    // asynchronous reset mid-wait
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
